// File: rtl/arbitrage_engine.sv
// Two-exchange arbitrage detector: UART quote receiver, packet parser, spread compute, UART report sender.
// Optional ARB_REPORT_ALL_EN: when defined, a report is sent for every accepted packet, including no-trade.
module arbitrage_engine #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int MIN_PROFIT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        packet_valid,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_busy,
    output logic        uart_tx_en,
    output logic [15:0] profit,
    output logic [1:0]  trade_action
);
    localparam int CPB = CLK_FREQ / BAUD;
    localparam int CW  = $clog2(CPB + 1);
    localparam logic [CW-1:0] CPB_M1  = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CPB / 2 - 1);
    localparam logic [16:0]   MIN_P   = 17'(MIN_PROFIT);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {P_HUNT, P_A_HI, P_A_LO, P_B_HI, P_B_LO, P_FOOTER} p_state_t;

    rx_state_t rx_state_q, rx_state_d;
    p_state_t  p_state_q, p_state_d;
    logic rx_meta_q, rx_sync_q, rx_prev_q;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
    logic [2:0] rx_bit_q, rx_bit_d, idx_q, idx_d;
    logic [7:0] rx_sh_q, rx_sh_d, data_q, data_d;
    logic rx_valid_q, rx_valid_d, rx_err_q, rx_err_d;
    logic [15:0] price_a_q, price_a_d, price_b_q, price_b_d, profit_q, profit_d, rep_profit_q, rep_profit_d;
    logic [1:0] action_q, action_d, rep_action_q, rep_action_d, action_new;
    logic [15:0] spread;
    logic pv_q, pv_d, active_q, active_d, en_q, en_d, report_req;
    logic tx_q, tx_d, busy_q, busy_d;
    logic [3:0] tx_bits_q, tx_bits_d;
    logic [8:0] tx_sh_q, tx_sh_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;  rx_sync_q <= 1'b1;  rx_prev_q <= 1'b1;
            rx_state_q <= RX_IDLE; rx_cnt_q <= '0; rx_bit_q <= '0; rx_sh_q <= '0;
            rx_valid_q <= 1'b0; rx_err_q <= 1'b0;
            p_state_q <= P_HUNT; price_a_q <= '0; price_b_q <= '0;
            profit_q <= '0; action_q <= 2'b00; pv_q <= 1'b0;
            active_q <= 1'b0; idx_q <= '0; en_q <= 1'b0; data_q <= 8'h00;
            rep_profit_q <= '0; rep_action_q <= 2'b00;
            tx_q <= 1'b1; busy_q <= 1'b0; tx_cnt_q <= '0; tx_bits_q <= '0; tx_sh_q <= '0;
        end else begin
            rx_meta_q <= uart_rx;  rx_sync_q <= rx_meta_q;  rx_prev_q <= rx_sync_q;
            rx_state_q <= rx_state_d; rx_cnt_q <= rx_cnt_d; rx_bit_q <= rx_bit_d; rx_sh_q <= rx_sh_d;
            rx_valid_q <= rx_valid_d; rx_err_q <= rx_err_d;
            p_state_q <= p_state_d; price_a_q <= price_a_d; price_b_q <= price_b_d;
            profit_q <= profit_d; action_q <= action_d; pv_q <= pv_d;
            active_q <= active_d; idx_q <= idx_d; en_q <= en_d; data_q <= data_d;
            rep_profit_q <= rep_profit_d; rep_action_q <= rep_action_d;
            tx_q <= tx_d; busy_q <= busy_d; tx_cnt_q <= tx_cnt_d; tx_bits_q <= tx_bits_d; tx_sh_q <= tx_sh_d;
        end
    end

    // Receiver: timers count down to zero, samples taken at mid-bit
    always_comb begin
        rx_state_d = rx_state_q; rx_cnt_d = rx_cnt_q; rx_bit_d = rx_bit_q; rx_sh_d = rx_sh_q;
        rx_valid_d = 1'b0; rx_err_d = 1'b0;
        case (rx_state_q)
            RX_IDLE: if (rx_prev_q && !rx_sync_q) begin
                rx_cnt_d = HALF_M1; rx_state_d = RX_START;
            end
            RX_START: if (rx_cnt_q == '0) begin
                if (!rx_sync_q) begin
                    rx_cnt_d = CPB_M1; rx_bit_d = '0; rx_state_d = RX_DATA;
                end else rx_state_d = RX_IDLE;
            end else rx_cnt_d = rx_cnt_q - 1'b1;
            RX_DATA: if (rx_cnt_q == '0) begin
                rx_sh_d  = {rx_sync_q, rx_sh_q[7:1]};
                rx_cnt_d = CPB_M1;
                if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                else rx_bit_d = rx_bit_q + 1'b1;
            end else rx_cnt_d = rx_cnt_q - 1'b1;
            RX_STOP: if (rx_cnt_q == '0) begin
                rx_state_d = RX_IDLE;
                if (rx_sync_q) rx_valid_d = 1'b1;
                else rx_err_d = 1'b1;
            end else rx_cnt_d = rx_cnt_q - 1'b1;
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        spread = (price_a_q > price_b_q) ? price_a_q - price_b_q : price_b_q - price_a_q;
        action_new = 2'b00;
        if ({1'b0, spread} > MIN_P) action_new = (price_a_q > price_b_q) ? 2'b10 : 2'b01;
    end

    always_comb begin
        p_state_d = p_state_q; price_a_d = price_a_q; price_b_d = price_b_q;
        profit_d = profit_q; action_d = action_q; pv_d = 1'b0;
        if (rx_err_q) begin
            p_state_d = P_HUNT;
        end else if (rx_valid_q) begin
            case (p_state_q)
                P_HUNT:   if (rx_sh_q == 8'hAA) p_state_d = P_A_HI;
                P_A_HI:   begin price_a_d[15:8] = rx_sh_q; p_state_d = P_A_LO; end
                P_A_LO:   begin price_a_d[7:0]  = rx_sh_q; p_state_d = P_B_HI; end
                P_B_HI:   begin price_b_d[15:8] = rx_sh_q; p_state_d = P_B_LO; end
                P_B_LO:   begin price_b_d[7:0]  = rx_sh_q; p_state_d = P_FOOTER; end
                P_FOOTER: begin
                    if (rx_sh_q == 8'h55) begin
                        pv_d = 1'b1; profit_d = spread; action_d = action_new;
                    end
                    p_state_d = P_HUNT;
                end
                default:  p_state_d = P_HUNT;
            endcase
        end
    end

`ifdef ARB_REPORT_ALL_EN
    assign report_req = pv_q;
`else
    assign report_req = pv_q && (action_q != 2'b00);
`endif

    // Report fields are snapshotted so an overlapping packet cannot tear a report
    always_comb begin
        active_d = active_q; idx_d = idx_q; en_d = 1'b0; data_d = data_q;
        rep_profit_d = rep_profit_q; rep_action_d = rep_action_q;
        if (!active_q) begin
            if (report_req) begin
                active_d = 1'b1; idx_d = 3'd1; en_d = 1'b1; data_d = 8'hAA;
                rep_profit_d = profit_q; rep_action_d = action_q;
            end
        end else if (!busy_q && !en_q) begin
            if (idx_q == 3'd5) active_d = 1'b0;
            else begin
                en_d  = 1'b1;
                idx_d = idx_q + 1'b1;
                case (idx_q)
                    3'd1:    data_d = {6'b0, rep_action_q};
                    3'd2:    data_d = rep_profit_q[15:8];
                    3'd3:    data_d = rep_profit_q[7:0];
                    default: data_d = 8'h55;
                endcase
            end
        end
    end

    always_comb begin
        tx_d = tx_q; busy_d = busy_q; tx_cnt_d = tx_cnt_q; tx_bits_d = tx_bits_q; tx_sh_d = tx_sh_q;
        if (busy_q) begin
            if (tx_cnt_q == '0) begin
                if (tx_bits_q == 4'd0) begin
                    busy_d = 1'b0; tx_d = 1'b1;
                end else begin
                    tx_d = tx_sh_q[0]; tx_sh_d = {1'b1, tx_sh_q[8:1]};
                    tx_bits_d = tx_bits_q - 1'b1; tx_cnt_d = CPB_M1;
                end
            end else tx_cnt_d = tx_cnt_q - 1'b1;
        end else if (en_q) begin
            tx_d = 1'b0; busy_d = 1'b1; tx_sh_d = {1'b1, data_q};
            tx_bits_d = 4'd9; tx_cnt_d = CPB_M1;
        end
    end

    assign uart_tx      = tx_q;
    assign packet_valid = pv_q;
    assign uart_tx_data = data_q;
    assign uart_tx_busy = busy_q;
    assign uart_tx_en   = en_q;
    assign profit       = profit_q;
    assign trade_action = action_q;
endmodule

// File: tb/tb_arbitrage_engine.sv
// Bench for arbitrage_engine: directed and random quote packets against a spread/report model.
module tb_arbitrage_engine;
    localparam int CLK_FREQ = 160;
    localparam int BAUD     = 10;
    localparam int CPB      = CLK_FREQ / BAUD;
    localparam int MINP     = 5;

    logic clk = 1'b0, rst = 1'b1, uart_rx = 1'b1;
    logic uart_tx, packet_valid, uart_tx_busy, uart_tx_en;
    logic [7:0] uart_tx_data;
    logic [15:0] profit;
    logic [1:0] trade_action;

    arbitrage_engine #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .MIN_PROFIT(MINP)) dut (
        .clk(clk), .rst(rst), .uart_rx(uart_rx), .uart_tx(uart_tx),
        .packet_valid(packet_valid), .uart_tx_data(uart_tx_data),
        .uart_tx_busy(uart_tx_busy), .uart_tx_en(uart_tx_en),
        .profit(profit), .trade_action(trade_action)
    );

    always #5 clk = ~clk;

    int checks = 0, passes = 0, fails = 0;
    int cyc = 0, pv_cnt = 0, pv_cyc = 0, en_cyc = 0, rst_cnt = 0;
    bit en_seen = 1'b0;
    logic [15:0] pv_profit = '0;
    logic [1:0]  pv_action = '0;
    logic [7:0]  txq[$];
    logic [15:0] m_profit = '0;
    logic [1:0]  m_action = '0;

    always @(negedge clk) begin
        cyc++;
        if (packet_valid) begin
            pv_cnt++; pv_cyc = cyc; pv_profit = profit; pv_action = trade_action; en_seen = 1'b0;
        end else if (uart_tx_en && !en_seen) begin
            en_seen = 1'b1; en_cyc = cyc;
        end
    end

    always @(posedge rst) rst_cnt++;

    // Line-level decoder of the report stream; frames cut by reset are dropped
    initial begin
        forever begin : dec
            logic [7:0] b;
            int rc;
            @(negedge uart_tx);
            rc = rst_cnt;
            repeat (CPB / 2) @(negedge clk);
            if (uart_tx == 1'b0 && !rst) begin
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = uart_tx;
                end
                repeat (CPB) @(negedge clk);
                if (uart_tx && rc == rst_cnt && !rst) txq.push_back(b);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic send_pkt(input logic [15:0] a, input logic [15:0] b, input logic [7:0] footer);
        send_byte(8'hAA, 1'b1);
        send_byte(a[15:8], 1'b1); send_byte(a[7:0], 1'b1);
        send_byte(b[15:8], 1'b1); send_byte(b[7:0], 1'b1);
        send_byte(footer, 1'b1);
    endtask

    task automatic check_outputs_reset(input string tag);
        chk({tag, "_tx"}, uart_tx, 1'b1);
        chk({tag, "_busy"}, uart_tx_busy, 1'b0);
        chk({tag, "_en"}, uart_tx_en, 1'b0);
        chk({tag, "_data"}, uart_tx_data, 8'h00);
        chk({tag, "_pv"}, packet_valid, 1'b0);
        chk({tag, "_profit"}, profit, 16'h0000);
        chk({tag, "_action"}, trade_action, 2'b00);
    endtask

    task automatic run_pkt(input string tag, input logic [15:0] a, input logic [15:0] b);
        int pv0;
        bit report;
        logic [7:0] exp[$];
        pv0 = pv_cnt;
        m_profit = (a > b) ? a - b : b - a;
        if (int'(m_profit) > MINP) m_action = (a > b) ? 2'b10 : 2'b01;
        else m_action = 2'b00;
`ifdef ARB_REPORT_ALL_EN
        report = 1'b1;
`else
        report = (m_action != 2'b00);
`endif
        if (report) begin
            exp.push_back(8'hAA); exp.push_back({6'b0, m_action});
            exp.push_back(m_profit[15:8]); exp.push_back(m_profit[7:0]); exp.push_back(8'h55);
        end
        txq.delete();
        send_pkt(a, b, 8'h55);
        repeat (4) @(negedge clk);
        chk({tag, "_pv_count"}, pv_cnt - pv0, 1);
        chk({tag, "_profit_at_pv"}, pv_profit, m_profit);
        chk({tag, "_action_at_pv"}, pv_action, m_action);
        if (report) chk({tag, "_en_latency"}, en_seen ? en_cyc - pv_cyc : -1, 1);
        else chk({tag, "_no_en"}, en_seen, 1'b0);
        if (report) begin
            for (int i = 0; i < 2000 && txq.size() < exp.size(); i++) @(negedge clk);
            repeat (CPB) @(negedge clk);
        end else repeat (300) @(negedge clk);
        chk({tag, "_tx_bytes"}, txq.size(), exp.size());
        for (int i = 0; i < exp.size() && i < txq.size(); i++)
            chk($sformatf("%s_tx_byte%0d", tag, i), txq[i], exp[i]);
        chk({tag, "_idle_busy"}, uart_tx_busy, 1'b0);
        chk({tag, "_held_profit"}, profit, m_profit);
    endtask

    initial begin
        int pv0;
        logic [15:0] a, b;
        repeat (3) @(negedge clk);
        check_outputs_reset("reset");
        rst = 1'b0;
        repeat (CPB) @(negedge clk);

        run_pkt("a_gt_b", 16'd4270, 16'd4235);
        run_pkt("b_gt_a", 16'd1000, 16'd1250);
        run_pkt("equal", 16'd4270, 16'd4270);
        run_pkt("at_min", 16'd100, 16'd105);
        run_pkt("above_min", 16'd106, 16'd100);
        run_pkt("max_b", 16'd0, 16'hFFFF);

        send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1);
        run_pkt("garbage_prefix", 16'd4270, 16'd4235);

        pv0 = pv_cnt;
        send_pkt(16'd1000, 16'd1250, 8'h54);
        repeat (200) @(negedge clk);
        chk("bad_footer_pv", pv_cnt - pv0, 0);
        chk("bad_footer_profit", profit, m_profit);
        chk("bad_footer_action", trade_action, m_action);

        pv0 = pv_cnt;
        send_byte(8'hAA, 1'b1); send_byte(8'h10, 1'b1);
        send_byte(8'hAE, 1'b0);
        repeat (CPB) @(negedge clk);
        send_byte(8'h10, 1'b1); send_byte(8'h8B, 1'b1); send_byte(8'h10, 1'b1);
        send_byte(8'hAE, 1'b1); send_byte(8'h55, 1'b1);
        repeat (50) @(negedge clk);
        chk("bad_stop_pv", pv_cnt - pv0, 0);
        run_pkt("after_bad_stop", 16'd2000, 16'd1500);

        for (int n = 0; n < 14; n++) begin
            a = 16'($urandom_range(0, 65535));
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = 16'(a + 16'($urandom_range(0, 12)) - 16'd6);
                default: b = 16'($urandom_range(0, 65535));
            endcase
            if ($urandom_range(0, 3) == 0) send_byte(8'($urandom_range(0, 8'hA9)), 1'b1);
            run_pkt($sformatf("rand%0d", n), a, b);
        end

        // Reset in the middle of the B_HI byte
        pv0 = pv_cnt;
        send_byte(8'hAA, 1'b1); send_byte(8'h10, 1'b1); send_byte(8'hAE, 1'b1);
        uart_rx = 1'b0;
        repeat (CPB * 3) @(negedge clk);
        rst = 1'b1;
        #1;
        check_outputs_reset("rst_rx");
        uart_rx = 1'b1;
        m_profit = '0; m_action = 2'b00;
        repeat (CPB * 2) @(negedge clk);
        rst = 1'b0;
        repeat (CPB) @(negedge clk);
        send_byte(8'h10, 1'b1); send_byte(8'h8B, 1'b1); send_byte(8'h55, 1'b1);
        repeat (50) @(negedge clk);
        chk("rst_rx_no_pv", pv_cnt - pv0, 0);
        chk("rst_rx_profit", profit, 16'h0000);

        // Reset while the profit high byte is on the wire
        txq.delete();
        send_pkt(16'd4270, 16'd4235, 8'h55);
        for (int i = 0; i < 1000 && txq.size() < 2; i++) @(negedge clk);
        chk("rst_tx_reached", txq.size(), 2);
        repeat (CPB * 4) @(negedge clk);
        rst = 1'b1;
        #1;
        check_outputs_reset("rst_tx");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (CPB * 20) @(negedge clk);
        chk("rst_tx_no_more_bytes", txq.size(), 2);
        chk("rst_tx_line_idle", uart_tx, 1'b1);
        chk("rst_tx_profit", profit, 16'h0000);

        run_pkt("after_rst", 16'd1000, 16'd1250);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/arbitrage_engine.md
# arbitrage_engine

Two-exchange price arbitrage detector sitting between a host serial link and on-board logic. It receives framed price quotes for the same asset from exchanges A and B over a 9600-baud 8N1 UART. It computes the absolute spread and the profitable trade direction, and transmits a framed result packet back over a UART transmitter. Internal handshake and result signals are exposed as debug outputs.

## Interface
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD, 9600: UART bit rate. CLKS_PER_BIT = CLK_FREQ/BAUD (5208 at defaults).
- MIN_PROFIT, 0: a trade is signalled only when the spread is strictly greater than this value, in cents.
- clk  in  1  system clock, single clock domain.
- rst  in  1  reset, asynchronous, active-high.
- uart_rx  in  1  serial quote input; idles high; asynchronous to clk.
- uart_tx  out  1  serial result output; idles high.
- packet_valid  out  1  one-cycle pulse when a complete, well-framed quote packet is accepted.
- uart_tx_data  out  8  byte currently loaded into the transmitter.
- uart_tx_busy  out  1  high while the transmitter is shifting a frame.
- uart_tx_en  out  1  one-cycle load strobe to the transmitter.
- profit  out  16  latest spread |A−B| in cents, unsigned.
- trade_action  out  2  00 = none, 01 = buy A / sell B (A<B), 10 = buy B / sell A (A>B), 11 = never driven.

## Operation
- **RX UART**
  - 2-flop synchroniser on uart_rx.
  - Falling edge starts a frame. The line is re-checked low at CLKS_PER_BIT/2, otherwise the receiver returns to idle.
  - Data bits are sampled at each mid-bit, LSB first.
  - The stop bit is sampled at mid-bit. High: a one-cycle rx_valid is issued with the byte. Low: the byte is dropped and the parser is reset to HUNT.
- **Parser FSM** states: HUNT, A_HI, A_LO, B_HI, B_LO, FOOTER.
  - HUNT: 0xAA goes to A_HI; any other byte is ignored.
  - A_HI → A_LO → B_HI → B_LO store price A and price B, each 16-bit big-endian unsigned cents.
  - FOOTER: 0x55 accepts the packet; any other byte discards it. Both outcomes return to HUNT.
- **Compute** on acceptance:
  - profit = A>B ? A−B : B−A, 16-bit and never negative.
  - trade_action = 10 if A>B and profit>MIN_PROFIT; 01 if B>A and profit>MIN_PROFIT; else 00.
  - profit and trade_action are registered and held until the next accepted packet.
- **TX sequencer**
  - Sends 5 bytes: 0xAA, {6'b0, trade_action}, profit[15:8], profit[7:0], 0x55.
  - Sent only when trade_action ≠ 00 (see Configuration).
  - For each byte it waits for uart_tx_busy low, drives uart_tx_data, and pulses uart_tx_en for one cycle.
- **TX UART**: 8N1, LSB first, CLKS_PER_BIT cycles per bit. uart_tx_busy rises the cycle after uart_tx_en and falls after the full stop bit.
- **Overlap**: if a packet is accepted while the sequencer is mid-report, profit and trade_action update but no new report is sent. packet_valid still pulses.

## Timing
- Reset values: uart_tx=1, packet_valid=0, uart_tx_data=0x00, uart_tx_busy=0, uart_tx_en=0, profit=0, trade_action=00; parser in HUNT.
- rst assertion takes effect immediately, including mid-frame or mid-transmit. Partial packets and reports are discarded, and uart_tx returns high at once.
- packet_valid pulses 1 cycle after the footer byte's rx_valid, i.e. about mid-stop-bit of the footer.
- profit and trade_action change in the same cycle packet_valid is high.
- The first uart_tx_en occurs 1 cycle after packet_valid, and the start bit drives uart_tx on the next cycle.
- Each byte takes 10×CLKS_PER_BIT cycles. The next uart_tx_en follows within 2 cycles of busy falling.
- An rx_valid and a tx completion in the same cycle are independent and both handled.

## Configuration
- ARB_REPORT_ALL_EN
  - Defined: a result packet is transmitted for every accepted quote packet, including trade_action=00.
  - Undefined (default): reports are sent only for trade_action ≠ 00.

## Test plan
- Send AA 10 AE 10 8B 55 (A=4270, B=4235) → packet_valid pulse, profit=35 (0x0023), trade_action=10; uart_tx emits AA 02 00 23 55.
- Send AA 03 E8 04 E2 55 (A=1000, B=1250) → profit=250, trade_action=01; uart_tx emits AA 01 00 FA 55.
- Send AA 10 AE 10 AE 55 (A=B) → profit=0, trade_action=00, uart_tx stays high. With ARB_REPORT_ALL_EN, AA 00 00 00 55 is emitted.
- Send 12 34 then a valid packet → the leading bytes are ignored and the packet is accepted normally. The same valid packet with footer 0x54 → no packet_valid and outputs unchanged.
- A byte sent with its stop bit low mid-packet → the frame is discarded. The next valid packet is accepted.
- Assert rst during the B_HI byte and during the TX profit byte → all outputs return to reset values immediately, uart_tx=1, and no partial report is sent.
